// File: rtl/sma_pkg.sv
// Shared types and defaults for the serial match arbiter.
// The optional SMA_PATTERN_PROG_EN build adds a programmable pattern port.
package sma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } sma_state_e;

  localparam logic [3:0] SMA_DEFAULT_PATTERN = 4'b1010;
  localparam int         SMA_DEFAULT_N_REQ   = 4;
  localparam int         SMA_DEFAULT_W       = 8;

endpackage

// File: rtl/serial_match_arbiter_if.sv
// Request/response bundle between requesters, consumer and the serial match arbiter.
// master = requester/consumer side, slave = arbiter side.
interface serial_match_arbiter_if
  import sma_pkg::*;
#(
  parameter int N_REQ = SMA_DEFAULT_N_REQ,
  parameter int W     = SMA_DEFAULT_W
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(W / 4 + 1);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [CW-1:0]      resp_count;
  logic               resp_ready;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_count
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_count
  );

endinterface

// File: rtl/sma_bit_matcher.sv
// Mealy non-overlapping 4-bit pattern detector; history restarts on clr or on a match.
module sma_bit_matcher (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic [3:0] pattern,
  output logic       match
);

  logic [2:0] hist_reg;
  logic [1:0] len_reg;

  // A match needs three remembered bits plus the bit arriving this cycle.
  assign match = bit_valid && !clr && (len_reg == 2'd3) && ({hist_reg, bit_in} == pattern);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist_reg <= '0;
      len_reg  <= '0;
    end else if (bit_valid) begin
      if (match) begin
        hist_reg <= '0;
        len_reg  <= '0;
      end else begin
        hist_reg <= {hist_reg[1:0], bit_in};
        if (len_reg != 2'd3) begin
          len_reg <= len_reg + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/serial_match_arbiter.sv
// Round-robin arbiter that serializes the granted word MSB first and counts pattern hits.
// Define SMA_PATTERN_PROG_EN to add a 4-bit pattern input sampled at acceptance.
module serial_match_arbiter
  import sma_pkg::*;
#(
  parameter int N_REQ = SMA_DEFAULT_N_REQ,
  parameter int W     = SMA_DEFAULT_W
)(
  input logic clk,
  input logic rst,
`ifdef SMA_PATTERN_PROG_EN
  input logic [3:0] pattern,
`endif
  serial_match_arbiter_if.slave bus
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(W / 4 + 1);
  localparam int BCW = $clog2(W);
  localparam logic [CW-1:0] MAX_COUNT = CW'(W / 4);

  sma_state_e state_reg, state_next;

  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   id_reg;
  logic [W-1:0]     word_reg;
  logic [BCW-1:0]   bit_cnt_reg;
  logic [CW-1:0]    count_reg;
  logic [3:0]       pattern_sel;

  logic [N_REQ-1:0] above_ptr;
  logic [N_REQ-1:0] masked_valid;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   hi_idx;
  logic [IDW-1:0]   lo_idx;
  logic             hi_found;
  logic             accept;
  logic             shift_en;
  logic             last_bit;
  logic             match;

  // Requesters after the last grant win first; otherwise wrap to the lowest index.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign above_ptr[gi]     = (IDW'(gi) > rr_ptr_reg);
      assign masked_valid[gi]  = bus.req_valid[gi] && above_ptr[gi];
      assign bus.req_ready[gi] = accept && (grant_idx == IDW'(gi));
    end
  endgenerate

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (masked_valid[i]) begin
        hi_found = 1'b1;
        hi_idx   = IDW'(i);
      end
      if (bus.req_valid[i]) begin
        lo_idx = IDW'(i);
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  assign accept   = (state_reg == IDLE) && (|bus.req_valid) && !rst;
  assign shift_en = (state_reg == SHIFT);
  assign last_bit = shift_en && (bit_cnt_reg == BCW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SMA_PATTERN_PROG_EN
  logic [3:0] pattern_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_reg <= SMA_DEFAULT_PATTERN;
    end else if (accept) begin
      pattern_reg <= pattern;
    end
  end

  assign pattern_sel = pattern_reg;
`else
  assign pattern_sel = SMA_DEFAULT_PATTERN;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg  <= IDW'(N_REQ - 1);
      id_reg      <= '0;
      word_reg    <= '0;
      bit_cnt_reg <= '0;
      count_reg   <= '0;
    end else if (accept) begin
      rr_ptr_reg  <= grant_idx;
      id_reg      <= grant_idx;
      word_reg    <= bus.req_data[int'(grant_idx)*W +: W];
      bit_cnt_reg <= '0;
      count_reg   <= '0;
    end else if (shift_en) begin
      word_reg    <= {word_reg[W-2:0], 1'b0};
      bit_cnt_reg <= bit_cnt_reg + 1'b1;
      if (match && (count_reg != MAX_COUNT)) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  sma_bit_matcher u_matcher (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .bit_valid (shift_en),
    .bit_in    (word_reg[W-1]),
    .pattern   (pattern_sel),
    .match     (match)
  );

  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_id    = id_reg;
  assign bus.resp_count = count_reg;

endmodule

// File: doc/serial_match_arbiter.md
SERIAL_MATCH_ARBITER -- requirements
Module: serial_match_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter W, default 8, SHALL set the word width in bits (multiple of 4, 4..32).
REQ-003 Derived constant CW = $clog2(W/4+1) SHALL set the width of the match count.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 req_valid  input  N_REQ  SHALL carry the per-requester request flags.
REQ-007 req_data  input  N_REQ*W  SHALL carry the request words; requester i uses bits [i*W +: W].
REQ-008 req_ready  output  N_REQ  SHALL be a one-hot acceptance pulse; at most one bit is high per cycle.
REQ-009 resp_valid  output  1  SHALL flag that a result is presented.
REQ-010 resp_id  output  $clog2(N_REQ)  SHALL give the index of the served requester.
REQ-011 resp_count  output  CW  SHALL give the number of non-overlapping pattern matches in the word.
REQ-012 resp_ready  input  1  SHALL be the consumer acceptance for the response.

Function
REQ-013 The FSM SHALL have three states:
- IDLE: arbitrate.
- SHIFT: serialize the word into the detector.
- RESP: hold the result.
REQ-014 In IDLE with any req_valid high, the block SHALL do all of the following in that cycle:
- Grant exactly one requester round-robin, starting after the last granted index.
- Pulse its req_ready.
- Latch its word and index.
- Clear the match count and detector history.
- Go to SHIFT.
REQ-015 A transfer SHALL occur only when req_valid[i] and req_ready[i] are both high; requests not granted wait, with no drop and no timeout.
REQ-016 SHIFT SHALL feed one bit per cycle, MSB first, for exactly W cycles, then go to RESP.
REQ-017 The detector SHALL be a Mealy non-overlapping matcher over bits fed since the last clear:
- A match occurs when the last 4 fed bits since the last clear or match equal the pattern.
- On a match it increments the count and clears its history in the same cycle.
REQ-018 Without SMA_PATTERN_PROG_EN the pattern SHALL be fixed at 4'b1010.
REQ-019 In RESP, the block SHALL hold resp_valid=1 with stable resp_id and resp_count; it returns to IDLE on the cycle resp_ready=1.
REQ-020 Latency SHALL be fixed: acceptance in cycle T gives resp_valid high from cycle T+W+1.
REQ-021 No new request SHALL be accepted while the FSM is in SHIFT or RESP, and req_ready SHALL be all zeros in those states.
REQ-022 An accept SHALL NOT occur in the same cycle as a RESP handshake; the earliest next accept is the cycle after resp_ready.
REQ-023 resp_count SHALL saturate at W/4; overflow is impossible by construction, and no wrap is permitted.

Reset
REQ-024 When rst=1, the block SHALL set:
- FSM to IDLE.
- req_ready=0, resp_valid=0, resp_id=0, resp_count=0.
- Detector history cleared.
- Round-robin pointer set so that index 0 has highest priority.
REQ-025 Reset asserted during SHIFT or RESP SHALL discard the in-flight word and SHALL produce no response for it.

Configuration
REQ-026 Macro SMA_PATTERN_PROG_EN defined: the block SHALL have an extra input port pattern (4 bits); pattern is sampled at acceptance and held for the whole word.
REQ-027 Macro SMA_PATTERN_PROG_EN undefined: there SHALL be no pattern port, and the pattern SHALL be the constant 4'b1010.

Structure
REQ-028 Package sma_pkg SHALL hold:
- the FSM state typedef (IDLE/SHIFT/RESP);
- the default pattern constant 4'b1010;
- the default N_REQ and W values.
REQ-029 The matcher SHALL be a sub-module sma_bit_matcher with ports clk, rst, clr, bit_valid, bit_in, pattern, and output match (combinational, Mealy).

Verification
REQ-030 req_valid[0] with word 0xAA (W=8), accepted at T -> resp_valid at T+9, resp_id=0, resp_count=2.
REQ-031 Single words 0x5A -> count 1; 0xA5 -> count 1; 0x00 -> count 0; 0x0A -> count 1.
REQ-032 All four req_valid high from reset, resp_ready=1 -> grants in order 0,1,2,3, each one accepted 10 cycles after the previous.
REQ-033 resp_ready held low 5 cycles in RESP -> resp_valid, resp_id and resp_count stable; req_ready stays 0 until after the handshake.
REQ-034 rst pulsed at SHIFT cycle 4 while req 2 is pending -> no response for the word; the next grant goes to the lowest pending index.
REQ-035 With SMA_PATTERN_PROG_EN, pattern=4'b1111 and word 0xFF -> count 2; pattern=4'b0110 and word 0x66 -> count 2.
